// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: a - b computed CHUNK bits per clock, LSB chunk first.
// Optional `ABS_DIFF_EN adds a FIX cycle that turns a negative result into |a - b|.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    count_r;
    logic             borrow_r;
    logic             borrow_out_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic [CHUNK:0]   sub_s;
    logic [WIDTH-1:0] diff_next_s;

    // The extra MSB of the widened difference is the chunk borrow-out.
    assign sub_s       = {1'b0, a_sh_r[CHUNK-1:0]} - {1'b0, b_sh_r[CHUNK-1:0]}
                         - {{CHUNK{1'b0}}, borrow_r};
    assign diff_next_s = WIDTH'({sub_s[CHUNK-1:0], diff_r} >> CHUNK);
    assign accept_s    = start && ((state_r == IDLE) || (state_r == DONE));

`ifdef ABS_DIFF_EN
    logic [WIDTH-1:0] fix_s;
    assign fix_s = borrow_r ? (~diff_r + WIDTH'(1)) : diff_r;
`endif

    // Next-state decode for the start/run/done sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            RUN: begin
                if (count_r == LAST) begin
`ifdef ABS_DIFF_EN
                    next_state_s = FIX;
`else
                    next_state_s = DONE;
`endif
                end else begin
                    next_state_s = RUN;
                end
            end
            FIX:     next_state_s = DONE;
            DONE: begin
                if (start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == RUN) || (next_state_s == FIX);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Operand shifters, borrow chain and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r       <= '0;
            b_sh_r       <= '0;
            diff_r       <= '0;
            count_r      <= '0;
            borrow_r     <= 1'b0;
            borrow_out_r <= 1'b0;
            zero_r       <= 1'b0;
        end else if (accept_s) begin
            a_sh_r       <= a;
            b_sh_r       <= b;
            diff_r       <= '0;
            count_r      <= '0;
            borrow_r     <= 1'b0;
            borrow_out_r <= 1'b0;
            zero_r       <= 1'b0;
        end else if (state_r == RUN) begin
            a_sh_r   <= a_sh_r >> CHUNK;
            b_sh_r   <= b_sh_r >> CHUNK;
            diff_r   <= diff_next_s;
            borrow_r <= sub_s[CHUNK];
            count_r  <= count_r + CW'(1);
            if (count_r == LAST) begin
                borrow_out_r <= sub_s[CHUNK];
`ifndef ABS_DIFF_EN
                zero_r       <= (diff_next_s == '0);
`endif
            end
`ifdef ABS_DIFF_EN
        end else if (state_r == FIX) begin
            diff_r <= fix_s;
            zero_r <= (fix_s == '0);
`endif
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;
    assign zero       = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8 with CHUNK=1 and CHUNK=4 instances).
module tb_serial_subtractor;
`ifdef ABS_DIFF_EN
    localparam int LAT  = 9;
    localparam int LAT4 = 3;
`else
    localparam int LAT  = 8;
    localparam int LAT4 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       busy, done, borrow_out, zero;
    logic [7:0] diff;
    logic       c4_start = 1'b0;
    logic [7:0] c4_a = 8'h00, c4_b = 8'h00;
    logic       c4_busy, c4_done, c4_borrow_out, c4_zero;
    logic [7:0] c4_diff;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];

    serial_subtractor #(.WIDTH(8), .CHUNK(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .zero(zero)
    );

    serial_subtractor #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(c4_start), .a(c4_a), .b(c4_b),
        .busy(c4_busy), .done(c4_done), .diff(c4_diff), .borrow_out(c4_borrow_out),
        .zero(c4_zero)
    );

    always #5 clk = ~clk;

    // Reference: {zero, borrow, diff}
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic       bw;
        bw = (x < y);
        r  = x - y;
`ifdef ABS_DIFF_EN
        if (bw) r = y - x;
`endif
        return {(r == 8'd0), bw, r};
    endfunction

    task automatic drive_start(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the cycle index (0 = cycle after accepting edge) of done, or -1 on timeout.
    task automatic wait_done(output int lat, output logic [9:0] got);
        lat = -1;
        got = 10'h000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                got = {zero, borrow_out, diff};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, diff, borrow_out, zero} !== 12'h000) begin
            fails++;
            $display("FAIL reset_hold got=%h want=000", {busy, done, diff, borrow_out, zero});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, diff, borrow_out, zero, c4_busy, c4_done} !== 14'h0000) begin
            fails++;
            $display("FAIL reset_release got=%h want=0000",
                     {busy, done, diff, borrow_out, zero, c4_busy, c4_done});
        end
    endtask

    task automatic test_basic(input logic [7:0] x, input logic [7:0] y);
        int lat;
        int busy_bad;
        logic [9:0] got, ex;
        drive_start(x, y);
        lat = -1; busy_bad = 0; got = 10'h000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 1 && k < LAT && busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k;
                got = {zero, borrow_out, diff};
                break;
            end
        end
        ex = exp_q.pop_front();
        tests++;
        if (lat != LAT) begin
            fails++; $display("FAIL basic_latency %h-%h got=%0d want=%0d", x, y, lat, LAT);
        end
        tests++;
        if (got !== ex) begin
            fails++; $display("FAIL basic_result %h-%h got=%h want=%h", x, y, got, ex);
        end
        tests++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_busy bad_cycles=%0d busy_at_done=%b want=0/0", busy_bad, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || {zero, borrow_out, diff} !== ex) begin
            fails++; $display("FAIL done_pulse_hold done=%b res=%h want=0 %h", done,
                              {zero, borrow_out, diff}, ex);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [9:0] got, ex;
        @(negedge clk);
        a = 8'h05; b = 8'h03; start = 1'b1;
        exp_q.push_back(model(8'h05, 8'h03));
        @(posedge clk);
        #1 a = 8'h10; b = 8'h01;
        exp_q.push_back(model(8'h10, 8'h01));
        wait_done(lat, got);
        ex = exp_q.pop_front();
        tests++;
        if (lat != LAT || got !== ex) begin
            fails++; $display("FAIL b2b_first lat=%0d res=%h want=%0d %h", lat, got, LAT, ex);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, got);
        ex = exp_q.pop_front();
        tests++;
        if (lat != LAT || got !== ex) begin
            fails++; $display("FAIL b2b_second lat=%0d res=%h want=%0d %h", lat, got, LAT, ex);
        end
    endtask

    task automatic test_abort();
        int lat;
        int dones;
        logic [9:0] got, ex;
        drive_start(8'h03, 8'h05);
        for (int k = 0; k < 5; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, diff, borrow_out, zero} !== 12'h000) begin
            fails++;
            $display("FAIL abort_async got=%h want=000", {busy, done, diff, borrow_out, zero});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++; $display("FAIL abort_no_done activity=%0d want=0", dones);
        end
        drive_start(8'h05, 8'h03);
        wait_done(lat, got);
        ex = exp_q.pop_front();
        tests++;
        if (lat != LAT || got !== ex) begin
            fails++; $display("FAIL abort_restart lat=%0d res=%h want=%0d %h", lat, got, LAT, ex);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [9:0] got, ex;
        logic [7:0] x, y;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            drive_start(x, y);
            wait_done(lat, got);
            ex = exp_q.pop_front();
            tests++;
            if (lat != LAT || got !== ex) begin
                fails++; $display("FAIL random %h-%h lat=%0d res=%h want=%0d %h", x, y, lat, got, LAT, ex);
            end
        end
    endtask

    task automatic test_chunk4();
        int lat;
        logic [9:0] got, ex;
        @(negedge clk);
        c4_a = 8'h3C; c4_b = 8'h4D; c4_start = 1'b1;
        exp_q.push_back(model(8'h3C, 8'h4D));
        @(posedge clk);
        #1 c4_start = 1'b0;
        lat = -1; got = 10'h000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (c4_done === 1'b1) begin
                lat = k;
                got = {c4_zero, c4_borrow_out, c4_diff};
                break;
            end
        end
        ex = exp_q.pop_front();
        tests++;
        if (lat != LAT4) begin
            fails++; $display("FAIL chunk4_latency got=%0d want=%0d", lat, LAT4);
        end
        tests++;
        if (got !== ex) begin
            fails++; $display("FAIL chunk4_result got=%h want=%h", got, ex);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic(8'h05, 8'h03);
        test_basic(8'h03, 8'h05);
        test_basic(8'h00, 8'h01);
        test_basic(8'hA7, 8'hA7);
        test_basic(8'hFF, 8'h00);
        test_back_to_back();
        test_abort();
        test_random();
        test_chunk4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
